// File: rtl/niosii_subsys_sw_debounce_if.sv
// Switch-conditioning bus between the board/firmware side and the debouncer.
// The debouncer takes the slave view; the PIO/firmware side takes the master view.
interface niosii_subsys_sw_debounce_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_out;
   logic [WIDTH-1:0] sw_change;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] edge_clear;
   logic [WIDTH-1:0] irq_mask;
   logic             irq;

   modport master (
      output sw_raw,
      output edge_clear,
      output irq_mask,
      input  sw_out,
      input  sw_change,
      input  edge_capture,
      input  irq
   );

   modport slave (
      input  sw_raw,
      input  edge_clear,
      input  irq_mask,
      output sw_out,
      output sw_change,
      output edge_capture,
      output irq
   );
endinterface

// File: rtl/niosii_subsys_sw_debounce.sv
// Slide-switch conditioner: per-line synchroniser, stability-counter debounce,
// change pulses, sticky edge capture and a masked, registered interrupt.
module niosii_subsys_sw_debounce #(
   parameter int               WIDTH         = 4,
   parameter int               SYNC_STAGES   = 2,
   parameter int               STABLE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
   input logic                        clk,
   input logic                        reset_n,
   niosii_subsys_sw_debounce_if.slave bus
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync_p [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;

   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] level_d;
   logic [WIDTH-1:0] change_q;
   logic [WIDTH-1:0] change_d;

   logic [WIDTH-1:0] capture_q;
   logic [WIDTH-1:0] capture_d;
   logic             irq_q;
   logic             irq_d;

   // ---- synchroniser chain ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_p[s] <= INIT_VALUE;
         end
      end else begin
         sync_p[0] <= bus.sw_raw;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_p[s] <= sync_p[s-1];
         end
      end
   end

   assign sync_q = sync_p[SYNC_STAGES-1];

   // ---- debounce: a level is accepted only after STABLE_CYCLES unbroken mismatches ----
   always_comb begin
      level_d  = level_q;
      change_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i]  = sync_q[i];
               change_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q  <= INIT_VALUE;
         change_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         level_q  <= level_d;
         change_q <= change_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---- edge capture and interrupt; a fresh change beats a same-cycle clear ----
   always_comb begin
      capture_d = change_q | (capture_q & ~bus.edge_clear);
      irq_d     = |(capture_q & bus.irq_mask);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         capture_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         capture_q <= capture_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.sw_out       = level_q;
   assign bus.sw_change    = change_q;
   assign bus.edge_capture = capture_q;
   assign bus.irq          = irq_q;

endmodule

// File: tb/tb_niosii_subsys_sw_debounce.sv
// Directed bench for the switch debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
// Edge counts in the step comments are relative to the last input change.
module tb_niosii_subsys_sw_debounce;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   niosii_subsys_sw_debounce_if #(.WIDTH(4)) bus ();

   niosii_subsys_sw_debounce #(
      .WIDTH        (4),
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(4),
      .INIT_VALUE   (4'b0000)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      reset_n        = 1'b0;
      bus.sw_raw     = 4'b0000;
      bus.edge_clear = 4'b0000;
      bus.irq_mask   = 4'b0000;

      // 1: reset held three cycles, then released
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("rst_sw_out", bus.sw_out, 4'b0000);
         check("rst_sw_change", bus.sw_change, 4'b0000);
         check("rst_edge_capture", bus.edge_capture, 4'b0000);
         check("rst_irq", bus.irq, 1'b0);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("rel_sw_out", bus.sw_out, 4'b0000);
         check("rel_sw_change", bus.sw_change, 4'b0000);
         check("rel_edge_capture", bus.edge_capture, 4'b0000);
      end

      // 2: bit 0 rises and is held
      bus.sw_raw = 4'b0001;
      tick(5);
      check("s2_sw_out_e5", bus.sw_out, 4'b0000);
      check("s2_change_e5", bus.sw_change, 4'b0000);
      tick(1);
      check("s2_sw_out_e6", bus.sw_out, 4'b0001);
      check("s2_change_e6", bus.sw_change, 4'b0001);
      check("s2_capture_e6", bus.edge_capture, 4'b0000);
      tick(1);
      check("s2_change_e7", bus.sw_change, 4'b0000);
      check("s2_capture_e7", bus.edge_capture, 4'b0001);
      check("s2_irq_masked", bus.irq, 1'b0);

      // 3a: 3-cycle glitch on bit 1 is rejected
      bus.sw_raw = 4'b0011;
      tick(3);
      bus.sw_raw = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         check("s3_glitch_sw_out", bus.sw_out, 4'b0001);
         check("s3_glitch_change", bus.sw_change, 4'b0000);
      end

      // 3b: 5-cycle high pulse on bit 1 is accepted, then debounced back low
      bus.sw_raw = 4'b0011;
      tick(5);
      check("s3_long_e5", bus.sw_out, 4'b0001);
      bus.sw_raw = 4'b0001;
      tick(1);
      check("s3_long_e6_out", bus.sw_out, 4'b0011);
      check("s3_long_e6_chg", bus.sw_change, 4'b0010);
      tick(4);
      check("s3_fall_e10", bus.sw_out, 4'b0011);
      tick(1);
      check("s3_fall_e11_out", bus.sw_out, 4'b0001);
      check("s3_fall_e11_chg", bus.sw_change, 4'b0010);

      // 4: return to 0000, then two bits toggle together
      bus.sw_raw = 4'b0000;
      tick(5);
      check("s4_fall_e5", bus.sw_out, 4'b0001);
      tick(1);
      check("s4_fall_e6_out", bus.sw_out, 4'b0000);
      check("s4_fall_e6_chg", bus.sw_change, 4'b0001);
      tick(2);
      bus.sw_raw = 4'b1010;
      tick(5);
      check("s4_multi_e5_out", bus.sw_out, 4'b0000);
      check("s4_multi_e5_chg", bus.sw_change, 4'b0000);
      tick(1);
      check("s4_multi_e6_out", bus.sw_out, 4'b1010);
      check("s4_multi_e6_chg", bus.sw_change, 4'b1010);

      // 5: clear-all lands in the same cycle as the 1010 pulse, so set wins
      bus.edge_clear = 4'b1111;
      tick(1);
      check("s5_setwins_all", bus.edge_capture, 4'b1010);
      tick(1);
      check("s5_clear_all", bus.edge_capture, 4'b0000);
      bus.edge_clear = 4'b0000;

      // 5: masked interrupt on bit 0
      bus.irq_mask = 4'b0001;
      bus.sw_raw   = 4'b1011;
      tick(6);
      check("s5_rise_out", bus.sw_out, 4'b1011);
      check("s5_rise_chg", bus.sw_change, 4'b0001);
      tick(1);
      check("s5_capture", bus.edge_capture, 4'b0001);
      check("s5_irq_not_yet", bus.irq, 1'b0);
      tick(1);
      check("s5_irq_set", bus.irq, 1'b1);
      bus.edge_clear = 4'b0001;
      tick(1);
      check("s5_capture_cleared", bus.edge_capture, 4'b0000);
      check("s5_irq_still", bus.irq, 1'b1);
      bus.edge_clear = 4'b0000;
      tick(1);
      check("s5_irq_drop", bus.irq, 1'b0);

      // 5: clear coincident with sw_change[0]
      bus.sw_raw = 4'b1010;
      tick(6);
      check("s5_fall_chg", bus.sw_change, 4'b0001);
      bus.edge_clear = 4'b0001;
      tick(1);
      check("s5_setwins_bit0", bus.edge_capture, 4'b0001);
      bus.edge_clear = 4'b0000;
      tick(1);
      check("s5_irq_again", bus.irq, 1'b1);
      bus.irq_mask = 4'b0000;
      tick(1);
      check("s5_irq_masked_off", bus.irq, 1'b0);
      check("s5_capture_kept", bus.edge_capture, 4'b0001);

      // 6: reset in the middle of debouncing bit 2
      bus.sw_raw = 4'b1110;
      tick(5);
      check("s6_pre_reset", bus.sw_out, 4'b1010);
      reset_n = 1'b0;
      tick(1);
      check("s6_reset_out", bus.sw_out, 4'b0000);
      check("s6_reset_chg", bus.sw_change, 4'b0000);
      check("s6_reset_capture", bus.edge_capture, 4'b0000);
      check("s6_reset_irq", bus.irq, 1'b0);
      reset_n = 1'b1;
      tick(5);
      check("s6_r5_out", bus.sw_out, 4'b0000);
      check("s6_r5_chg", bus.sw_change, 4'b0000);
      tick(1);
      check("s6_r6_out", bus.sw_out, 4'b1110);
      check("s6_r6_chg", bus.sw_change, 4'b1110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
